// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types and constants for the snapshot readout controller
package regfile_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    STREAM,
    DONE
  } state_t;

  localparam int DEF_SETTLE_CYCLES  = 3;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Index width that stays legal for a single-entry range.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_snapshot_ctrl_if.sv
// rtl/regfile_snapshot_ctrl_if.sv - snapshot readout stream bus
interface regfile_snapshot_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 5
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_W-1:0]     out_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data, out_addr, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_addr, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, pointer held by the parent
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  // Walk from farthest to nearest so the first set bit after ptr is the final winner.
  always_comb begin
    grant = '0;
    if (en) begin
      for (int i = NUM_REQ; i >= 1; i--) begin
        if (req[(int'(ptr) + i) % NUM_REQ]) begin
          grant = '0;
          grant[(int'(ptr) + i) % NUM_REQ] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_snapshot_ctrl.sv
// rtl/regfile_snapshot_ctrl.sv - arbitrates snapshot requests, pulses latch, streams the snapshot
module regfile_snapshot_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_FILE_SIZE  = 32,
  parameter int NUM_REQ        = 3,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int ADDR_W        = addr_w(REG_FILE_SIZE)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQ-1:0]                      req,
  output logic [NUM_REQ-1:0]                      grant,
  output logic                                    latch,
  input  logic                                    latch_ready,
  input  logic [REG_FILE_SIZE-1:0][DATA_WIDTH-1:0] rf_data,
  regfile_snapshot_ctrl_if.master                 out_if,
  output logic                                    busy,
  output logic                                    err_timeout
);

  localparam int IDX_W = addr_w(NUM_REQ);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(SETTLE_CYCLES - 1 + TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(REG_FILE_SIZE - 1);

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [CNT_W-1:0]     cnt;
  logic [ADDR_W-1:0]    addr;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 owner_req;

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) onehot_idx = IDX_W'(i);
    end
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .en    (state == IDLE),
    .grant (arb_grant)
  );

  assign owner_req = |(req & grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= IDX_W'(NUM_REQ - 1);
      cnt         <= '0;
      addr        <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= arb_grant;
            state <= LATCH;
          end
        end
        LATCH: begin
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          // Owner withdrawal wins over both ready and timeout.
          if (!owner_req) begin
            state <= DONE;
          end else if (cnt >= SETTLE_LAST && latch_ready) begin
            addr  <= '0;
            state <= STREAM;
          end else if (cnt >= TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STREAM: begin
          if (!owner_req) begin
            state <= DONE;
          end else if (out_if.out_ready) begin
            if (addr == LAST_ADDR) state <= DONE;
            else                   addr  <= addr + 1'b1;
          end
        end
        DONE: begin
          grant <= '0;
          ptr   <= onehot_idx(grant);
          addr  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign latch            = (state == LATCH);
  assign busy             = (state != IDLE);
  assign out_if.out_valid = (state == STREAM);
  assign out_if.out_addr  = addr;
  assign out_if.out_last  = (state == STREAM) && (addr == LAST_ADDR);
  assign out_if.out_data  = (state == STREAM) ? rf_data[addr] : '0;

endmodule

// File: tb/tb_regfile_snapshot_ctrl.sv
// tb/tb_regfile_snapshot_ctrl.sv - directed self-checking bench for regfile_snapshot_ctrl
module tb_regfile_snapshot_ctrl;

  localparam int DW     = 16;
  localparam int RFS    = 32;
  localparam int NR     = 3;
  localparam int AW     = 5;
  localparam int SETTLE = 3;
  localparam int TMO    = 255;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NR-1:0]           req;
  logic [NR-1:0]           grant;
  logic                    latch;
  logic                    latch_ready;
  logic [RFS-1:0][DW-1:0]  rf_data;
  logic                    busy;
  logic                    err_timeout;

  int checks = 0;
  int errors = 0;

  regfile_snapshot_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  regfile_snapshot_ctrl #(
    .DATA_WIDTH     (DW),
    .REG_FILE_SIZE  (RFS),
    .NUM_REQ        (NR),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .latch       (latch),
    .latch_ready (latch_ready),
    .rf_data     (rf_data),
    .out_if      (bus),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_latch(input string tag);
    int k;
    for (k = 0; k < 40 && latch !== 1'b1; k++) step();
    chk({tag, "_latch_seen"}, 32'(latch), 1);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    for (k = 0; k < 40 && bus.out_valid !== 1'b1; k++) step();
    chk({tag, "_valid_seen"}, 32'(bus.out_valid), 1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 40 && busy !== 1'b0; k++) step();
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_grant_clr"}, 32'(grant), 0);
  endtask

  // Accepts every beat (out_ready held 1) and checks order, data and last flag.
  task automatic drain(input string tag, output int beats);
    int k;
    beats = 0;
    wait_valid(tag);
    for (k = 0; k < 200 && bus.out_valid === 1'b1; k++) begin
      chk({tag, "_addr"}, 32'(bus.out_addr), beats);
      chk({tag, "_data"}, 32'(bus.out_data), 32'(16'hA500 + beats));
      chk({tag, "_last"}, 32'(bus.out_last), (beats == RFS - 1) ? 1 : 0);
      beats++;
      step();
    end
  endtask

  task automatic do_txn(input string tag, input logic [NR-1:0] exp_g);
    int beats;
    wait_latch(tag);
    chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
    drain(tag, beats);
    chk({tag, "_beats"}, beats, RFS);
    wait_idle(tag);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, lat, beats, cyc, idx;
    logic seen;

    reset          = 1'b1;
    req            = '0;
    latch_ready    = 1'b1;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < RFS; i++) rf_data[i] = 16'(16'hA500 + i);
    step();
    step();

    chk("rst_grant", 32'(grant), 0);
    chk("rst_latch", 32'(latch), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_last",  32'(bus.out_last), 0);
    chk("rst_addr",  32'(bus.out_addr), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_err",   32'(err_timeout), 0);
    reset = 1'b0;
    step();

    // Single request: grant and latch on the first edge, data SETTLE+1 edges later.
    req = 3'b001;
    step();
    chk("b_grant", 32'(grant), 32'h1);
    chk("b_latch", 32'(latch), 1);
    chk("b_busy",  32'(busy), 1);
    step();
    chk("b_latch_1cyc", 32'(latch), 0);
    lat = 1;
    for (k = 0; k < 20 && bus.out_valid !== 1'b1; k++) begin
      step();
      lat++;
    end
    chk("b_latency", lat, SETTLE + 1);
    drain("b", beats);
    chk("b_beats", beats, RFS);
    req = '0;
    chk("b_done_busy", 32'(busy), 1);
    step();
    chk("b_idle_busy",  32'(busy), 0);
    chk("b_idle_grant", 32'(grant), 0);

    // Contention from a fresh pointer.
    do_reset();
    req = 3'b111;
    do_txn("c0", 3'b001);
    do_txn("c1", 3'b010);
    do_txn("c2", 3'b100);
    do_txn("c3", 3'b001);
    req = '0;

    // Backpressure: ready alternates 0,1 starting on the first valid cycle.
    req = 3'b010;
    wait_latch("d");
    chk("d_grant", 32'(grant), 32'h2);
    wait_valid("d");
    cyc = 0;
    idx = 0;
    for (k = 0; k < 200 && bus.out_valid === 1'b1; k++) begin
      bus.out_ready = cyc[0];
      chk("d_addr", 32'(bus.out_addr), idx);
      chk("d_data", 32'(bus.out_data), 32'(16'hA500 + idx));
      if (bus.out_ready) idx++;
      cyc++;
      step();
    end
    chk("d_cycles", cyc, 2 * RFS);
    chk("d_words", idx, RFS);
    bus.out_ready = 1'b1;
    req = '0;
    wait_idle("d");

    // latch_ready never arrives.
    latch_ready = 1'b0;
    req = 3'b100;
    wait_latch("e");
    chk("e_grant", 32'(grant), 32'h4);
    k = 0;
    seen = 1'b0;
    while (k < 400 && err_timeout !== 1'b1) begin
      step();
      k++;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("e_tmo_cycles", k, 1 + SETTLE + TMO);
    chk("e_no_valid", 32'(seen), 0);
    req = '0;
    wait_idle("e");
    latch_ready = 1'b1;
    req = 3'b001;
    do_txn("e_next", 3'b001);
    req = '0;
    chk("e_err_sticky", 32'(err_timeout), 1);

    // Abort: requester 1 withdraws after beat 10, requester 2 is pending.
    req = 3'b110;
    wait_latch("f");
    chk("f_grant", 32'(grant), 32'h2);
    wait_valid("f");
    for (k = 0; k < 60 && bus.out_addr !== AW'(11); k++) step();
    chk("f_addr11", 32'(bus.out_addr), 11);
    req = 3'b100;
    step();
    chk("f_valid_drop", 32'(bus.out_valid), 0);
    chk("f_done_busy",  32'(busy), 1);
    step();
    chk("f_idle_busy",  32'(busy), 0);
    chk("f_idle_grant", 32'(grant), 0);
    do_txn("f_next", 3'b100);
    req = '0;

    // Move the pointer to 0, then reset in the middle of requester 1's stream.
    req = 3'b001;
    do_txn("g_pre", 3'b001);
    req = 3'b010;
    wait_latch("g");
    chk("g_grant", 32'(grant), 32'h2);
    wait_valid("g");
    for (k = 0; k < 60 && bus.out_addr !== AW'(5); k++) step();
    chk("g_addr5", 32'(bus.out_addr), 5);
    #2;
    reset = 1'b1;
    #1;
    chk("g_rst_grant", 32'(grant), 0);
    chk("g_rst_latch", 32'(latch), 0);
    chk("g_rst_valid", 32'(bus.out_valid), 0);
    chk("g_rst_last",  32'(bus.out_last), 0);
    chk("g_rst_addr",  32'(bus.out_addr), 0);
    chk("g_rst_busy",  32'(busy), 0);
    chk("g_rst_err",   32'(err_timeout), 0);
    step();
    step();
    reset = 1'b0;
    req = 3'b011;
    wait_latch("g_post");
    chk("g_post_grant", 32'(grant), 32'h1);
    req = '0;
    wait_idle("g_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_snapshot_ctrl.md
Name: regfile_snapshot_ctrl

Overview:
Sequences the register-file snapshot latch and shares its latched output among several readers (debug UART, SPI host, trace logger). Round-robin arbitrates snapshot requests and pulses the latch's `latch` input. Waits for the snapshot to settle, then streams all REG_FILE_SIZE words to the granted requester over a valid/ready bus. Sits between the latch's latch/latch_ready/data_out ports and the readout clients.

Parameters:
DATA_WIDTH, 16, width of each register word
REG_FILE_SIZE, 32, number of words per snapshot (>=2)
NUM_REQ, 3, number of requesters (>=2)
SETTLE_CYCLES, 3, cycles from latch pulse end to snapshot data valid (>=1)
TIMEOUT_CYCLES, 255, maximum additional cycles waiting for latch_ready before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester snapshot request, level, held until done
grant  out  NUM_REQ  one-hot owner of current transaction, 0 when idle
latch  out  1  one-cycle pulse to the snapshot latch
latch_ready  in  1  from the snapshot latch; 1 = snapshot usable
rf_data  in  DATA_WIDTH x REG_FILE_SIZE  latched register file contents
out_data  out  DATA_WIDTH  rf_data[out_addr] while out_valid
out_addr  out  clog2(REG_FILE_SIZE)  word index of current beat
out_valid  out  1  beat valid
out_ready  in  1  owner accepts beat
out_last  out  1  high with the beat at index REG_FILE_SIZE-1
busy  out  1  state != IDLE
err_timeout  out  1  sticky; set when a latch_ready wait times out

Behaviour:
- Reset (async, active-high):
  - state=IDLE; grant, latch, out_valid, out_last, out_addr, busy, err_timeout = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LATCH, SETTLE, STREAM, DONE; all outputs registered or decoded from registered state.
- IDLE:
  - If |req, select the first set bit after the last winner (wrapping).
  - At that edge: grant<=onehot(winner), state<=LATCH.
- LATCH:
  - latch=1 for exactly this one cycle.
  - Next edge: state<=SETTLE, cnt<=0.
- SETTLE:
  - cnt increments each edge.
  - When cnt>=SETTLE_CYCLES-1 and latch_ready=1: state<=STREAM, out_addr<=0.
  - If latch_ready stays 0 for TIMEOUT_CYCLES cycles after the settle count: err_timeout<=1, state<=DONE, no beats issued.
- STREAM:
  - out_valid=1; out_data=rf_data[out_addr]; out_last=(out_addr==REG_FILE_SIZE-1).
  - On valid&ready: if last, state<=DONE; else out_addr++.
  - out_data/out_addr stable while valid&!ready.
- DONE (one cycle):
  - grant<=0; pointer<=winner.
  - Next edge: state<=IDLE.
- Latency, req seen in IDLE at edge N:
  - grant at edge N; latch high in cycle N..N+1.
  - Earliest out_valid at edge N+1+SETTLE_CYCLES (N+4 at default).
- Abort: if the granted req bit drops in SETTLE or STREAM, go to DONE at the next edge. out_valid falls at that edge; any partial stream is discarded.
- Boundary conditions:
  - Simultaneous requests: exactly one grant; others wait, no starvation. With all NUM_REQ requesting continuously, each is served once per NUM_REQ transactions.
  - A requester still asserting req after its DONE is regranted only per round-robin order.
  - New req bits during a transaction are ignored until IDLE.
  - Reset mid-transaction: immediate return to reset values. Partial streams are not resumed; err_timeout is cleared.
  - latch_ready=1 already during LATCH does not shortcut SETTLE_CYCLES.
- Widths:
  - out_addr and cnt are unsigned; cnt is wide enough for max(SETTLE_CYCLES, TIMEOUT_CYCLES).
  - out_addr never exceeds REG_FILE_SIZE-1 (no wrap).

Decomposition:
- Package regfile_ctrl_pkg:
  - state_t enum (IDLE, LATCH, SETTLE, STREAM, DONE).
  - ADDR_W function/localparam (clog2).
  - Default SETTLE/TIMEOUT constants.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs req, ptr, en; output one-hot grant.
  - Purely combinational with pointer held in the parent.

Test Plan:
- Single request: req=3'b001, out_ready=1, latch_ready=1 -> latch pulse 1 cycle, first out_valid 4 cycles after grant, 32 beats addr 0..31, out_last on addr 31, grant returns to 0.
- Contention: req=3'b111 held for 3 transactions -> grants in order 001, 010, 100; then 001 again.
- Backpressure: toggle out_ready 1/0 every cycle, rf_data[i]=16'hA500+i -> every word seen once in order, data stable during stalls, 64 cycles of STREAM.
- Timeout: latch_ready held 0 -> after 3+255 cycles in SETTLE, err_timeout=1, no out_valid, grant clears, next request still serviced.
- Abort: drop req[1] after beat 10 -> out_valid low next edge, DONE, then IDLE; a pending req[2] is granted afterwards.
- Reset mid-stream: assert reset asynchronously at beat 5 -> all outputs 0 immediately, state IDLE. After release, req=3'b001 is granted first.
